onehot_ring_encoder: RTL and testbench

//  Parametrised, registered binary-to-one-hot encoder with rotate commands and valid/ready flow control.
//  - Holds a one-hot index register.
//  - Each accepted command loads a new index, rotates the current one left/right by N, or re-emits it.
//  - Feeds select/grant lines of downstream muxes and arbiters that need a registered, always-one-hot vector.

---
 rtl/onehot_ring_encoder.sv | 113 +++++++++++
 tb/tb_onehot_ring_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_ring_encoder.sv
// onehot_ring_encoder
//   Registered binary-to-one-hot encoder with LOAD / ROTL / ROTR / HOLD
//   commands and valid/ready flow control on both sides.
//   The index register is always valid, so dataout is always exactly one-hot.
//   When the output is EMPTY, dataout keeps its last value; consumers must
//   qualify it with out_valid.
//
// Parameters
//   IN_W       binary index width; output width is 2**IN_W
//   RESET_IDX  index that is hot after reset (must be < 2**IN_W)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   command valid
//   in_ready   command accepted when in_valid & in_ready (combinational)
//   cmd        00 LOAD, 01 ROTL, 10 ROTR, 11 HOLD
//   datain     LOAD: new index; ROTL/ROTR: step count; HOLD: ignored
//   out_valid  dataout/wrap carry a result
//   out_ready  consumer takes the result when out_valid & out_ready
//   dataout    one-hot vector
//   wrap       the rotation of this result crossed the MSB <-> LSB boundary
//   bin_out    (only with ONEHOT_BINOUT_EN defined) binary index of dataout
//
// Optional feature macro: ONEHOT_BINOUT_EN
module onehot_ring_encoder #(
  parameter int IN_W      = 4,
  parameter int RESET_IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           cmd,
  input  logic [IN_W-1:0]      datain,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**IN_W-1:0]   dataout,
  output logic                 wrap
`ifdef ONEHOT_BINOUT_EN
  ,
  output logic [IN_W-1:0]      bin_out
`endif
);

  localparam int OUT_W = 2**IN_W;
  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
  localparam logic [IN_W-1:0]  RST_IDX = IN_W'(RESET_IDX);

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_ROTL = 2'b01,
    CMD_ROTR = 2'b10,
    CMD_HOLD = 2'b11
  } cmd_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e          state;
  logic [IN_W-1:0] idx;
  logic [IN_W-1:0] nidx;
  logic            nwrap;
  logic            accept;

  assign out_valid = (state == FULL);
  assign in_ready  = (state == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;

`ifdef ONEHOT_BINOUT_EN
  // idx is already the registered binary form of dataout.
  assign bin_out = idx;
`endif

  // Natural IN_W-bit wrap gives modulo-OUT_W arithmetic; a zero step can
  // never satisfy the wrap comparisons, so it reports no wrap.
  always_comb begin
    nidx  = idx;
    nwrap = 1'b0;
    case (cmd_e'(cmd))
      CMD_LOAD: nidx = datain;
      CMD_ROTL: begin
        nidx  = idx + datain;
        nwrap = (nidx < idx);
      end
      CMD_ROTR: begin
        nidx  = idx - datain;
        nwrap = (nidx > idx);
      end
      default:  nidx = idx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      idx     <= RST_IDX;
      dataout <= ONE << RST_IDX;
      wrap    <= 1'b0;
    end else if (accept) begin
      // Covers both EMPTY->FULL and FULL->FULL with simultaneous consume.
      state   <= FULL;
      idx     <= nidx;
      dataout <= ONE << nidx;
      wrap    <= nwrap;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_onehot_ring_encoder.sv
module tb_onehot_ring_encoder;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] ROTL = 2'b01;
  localparam logic [1:0] ROTR = 2'b10;
  localparam logic [1:0] HOLD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  cmd;
  logic [3:0]  datain;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dataout;
  logic        wrap;
`ifdef ONEHOT_BINOUT_EN
  logic [3:0]  bin_out;
`endif

  onehot_ring_encoder #(.IN_W(4), .RESET_IDX(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd       (cmd),
    .datain    (datain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .wrap      (wrap)
`ifdef ONEHOT_BINOUT_EN
    ,
    .bin_out   (bin_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {wrap, dataout}
  logic [16:0] sb_q[$];

  // Reference model state
  logic [3:0] m_idx = 4'd0;
  logic       m_ov  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setin(input logic iv, input logic [1:0] c, input logic [3:0] d, input logic ordy);
    in_valid  = iv;
    cmd       = c;
    datain    = d;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [1:0] c, input logic [3:0] d, input logic ordy);
    setin(iv, c, d, ordy);
    tick();
  endtask

  // Model / stimulus side of the scoreboard: sees the handshake that the
  // coming rising edge will perform and pushes the expected result.
  always @(negedge clk) begin
    logic       acc;
    logic [3:0] n;
    logic       w;
    if (!rst_n) begin
      m_idx = 4'd0;
      m_ov  = 1'b0;
      sb_q.delete();
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || out_ready)});
      acc = in_valid && (!m_ov || out_ready);
      if (acc) begin
        n = m_idx;
        w = 1'b0;
        case (cmd)
          LOAD: n = datain;
          ROTL: begin n = m_idx + datain; w = (n < m_idx); end
          ROTR: begin n = m_idx - datain; w = (n > m_idx); end
          default: n = m_idx;
        endcase
        sb_q.push_back({w, 16'h0001 << n});
        m_idx = n;
        m_ov  = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: pops and compares whenever the DUT hands over a result.
  always @(negedge clk) begin
    logic [16:0] e;
    int          k;
    if (rst_n) begin
      chk("onehot", {31'd0, $onehot(dataout)}, 32'd1);
`ifdef ONEHOT_BINOUT_EN
      k = -1;
      for (int i = 0; i < 16; i++) if (dataout[i]) k = i;
      chk("bin_out", {28'd0, bin_out}, k);
`endif
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_dataout", {16'd0, dataout}, {16'd0, e[15:0]});
          chk("sb_wrap", {31'd0, wrap}, {31'd0, e[16]});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    setin(1'b1, LOAD, 4'd9, 1'b1);

    // 1. Reset, with a command pending throughout
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_dataout", {16'd0, dataout}, 32'h0001);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_wrap", {31'd0, wrap}, 32'd0);
    end
    setin(1'b0, LOAD, 4'd0, 1'b1);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // 2. LOAD 9, then every index back-to-back
    drive(1'b1, LOAD, 4'd9, 1'b1);
    chk("load9_dataout", {16'd0, dataout}, 32'h0200);
    chk("load9_valid", {31'd0, out_valid}, 32'd1);
    chk("load9_wrap", {31'd0, wrap}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, LOAD, 4'(i), 1'b1);
      chk("b2b_dataout", {16'd0, dataout}, 32'd1 << i);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    end

    // 3. Wrap cases
    drive(1'b1, LOAD, 4'd15, 1'b1);
    drive(1'b1, ROTL, 4'd1, 1'b1);
    chk("rotl_wrap_data", {16'd0, dataout}, 32'h0001);
    chk("rotl_wrap_flag", {31'd0, wrap}, 32'd1);
    drive(1'b1, LOAD, 4'd1, 1'b1);
    drive(1'b1, ROTR, 4'd3, 1'b1);
    chk("rotr_wrap_data", {16'd0, dataout}, 32'h4000);
    chk("rotr_wrap_flag", {31'd0, wrap}, 32'd1);
    drive(1'b1, ROTL, 4'd0, 1'b1);
    chk("rotl0_data", {16'd0, dataout}, 32'h4000);
    chk("rotl0_wrap", {31'd0, wrap}, 32'd0);
    drive(1'b1, ROTL, 4'd3, 1'b1);
    chk("rotl3_data", {16'd0, dataout}, 32'h0002);
    chk("rotl3_wrap", {31'd0, wrap}, 32'd1);
    drive(1'b1, HOLD, 4'd7, 1'b1);
    chk("hold_data", {16'd0, dataout}, 32'h0002);
    chk("hold_wrap", {31'd0, wrap}, 32'd0);

    // 4. Backpressure: idx 1 -> ROTR 2 -> 15 with wrap, then stall
    drive(1'b1, ROTR, 4'd2, 1'b1);
    chk("pre_stall_data", {16'd0, dataout}, 32'h8000);
    chk("pre_stall_wrap", {31'd0, wrap}, 32'd1);
    setin(1'b1, LOAD, 4'd5, 1'b0);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", {16'd0, dataout}, 32'h8000);
      chk("stall_wrap", {31'd0, wrap}, 32'd1);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_data", {16'd0, dataout}, 32'h0020);
    chk("release_wrap", {31'd0, wrap}, 32'd0);

    // 5. Reset in the middle of a stall
    drive(1'b1, LOAD, 4'd7, 1'b1);
    chk("idx7_data", {16'd0, dataout}, 32'h0080);
    drive(1'b1, ROTL, 4'd1, 1'b0);
    drive(1'b1, ROTL, 4'd1, 1'b0);
    chk("stall7_data", {16'd0, dataout}, 32'h0080);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {16'd0, dataout}, 32'h0001);
    chk("midrst_wrap", {31'd0, wrap}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, LOAD, 4'd0, 1'b1);

    // 6. Random traffic checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    // Drain and confirm nothing was lost
    drive(1'b0, LOAD, 4'd0, 1'b1);
    drive(1'b0, LOAD, 4'd0, 1'b1);
    chk("drain_queue", sb_q.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
